bus_interrupt_arbiter: RTL and testbench
========================================

# bus_interrupt_arbiter

Shares the microprocessor's single interrupt line between four bus peripherals: mouse, timer, IR transmitter, and a spare slot. It captures each peripheral's interrupt request into a pending register and selects one request at a time by priority. It raises the CPU interrupt, and on CPU acknowledge returns a one-cycle acknowledge pulse to the selected source. The block is a memory-mapped bus peripheral: the CPU reads pending bits and the active vector, and reads or writes the enable mask, over the shared 8-bit tristate data bus.

## Interface
- BASE_ADDR, 8'hF0, bus base address; occupies BASE_ADDR..BASE_ADDR+2
- NUM_SRC, 4, number of interrupt sources; fixed at 4, vector is 2 bits
- CLK_100  input  1  system clock, 100 MHz
- RESET  input  1  synchronous, active-high
- SRC_IRQ  input  4  per-source interrupt raise; level, held high by the source until acknowledged; bit 0 is the mouse
- SRC_ACK  output  4  per-source acknowledge; one-cycle pulse, at most one bit high
- CPU_INTERRUPT_RAISE  output  1  interrupt request to the CPU; registered
- CPU_INTERRUPT_ACK  input  1  CPU acknowledge
- BUS_ADDR  input  8  bus address
- BUS_DATA  inout  8  bus data; driven only during reads of this block, Z otherwise
- BUS_WE  input  1  1 = CPU writes, 0 = CPU reads

## Operation
- Edge capture:
  - prev_irq[3:0] registers SRC_IRQ every cycle.
  - pending[i] is set at any edge where SRC_IRQ[i]=1 and prev_irq[i]=0.
  - pending[i] is cleared at the edge that acknowledges source i.
  - Simultaneous set and clear of the same bit: set wins.
- Mask register enable[3:0]:
  - Source i is eligible only when pending[i] & enable[i].
  - Masked pending bits are retained; unmasking later makes them eligible.
- FSM states: IDLE, RAISE, ACK, GAP.
  - IDLE: if any eligible bit, latch vector = selected index and go to RAISE. Otherwise stay in IDLE. CPU_INTERRUPT_ACK is ignored in IDLE.
  - RAISE: CPU_INTERRUPT_RAISE=1. Vector is frozen; mask or pending changes do not withdraw the request. On CPU_INTERRUPT_ACK=1, clear pending[vector] and go to ACK.
  - ACK: SRC_ACK[vector]=1, CPU_INTERRUPT_RAISE=0; go to GAP unconditionally.
  - GAP: all outputs idle for one cycle, letting the CPU drop its acknowledge; go to IDLE.
- Selection is fixed priority, lowest index wins. This is the default; see Configuration for the alternative.
- Bus map, reads only when BUS_WE=0:
  - BASE+0 status: {busy, 3'b0, pending[3:0]}, where busy = (state != IDLE).
  - BASE+1 mask: {4'b0, enable[3:0]}.
  - BASE+2 vector: {busy, 5'b0, vector[1:0]}.
- Bus writes: BUS_WE=1 with BUS_ADDR=BASE+1 loads enable <= BUS_DATA[3:0]. Writes to BASE+0 and BASE+2 are ignored.
- Reads of other addresses, and all cycles with BUS_WE=1, leave BUS_DATA at Z.

## Timing
- Reset values:
  - CPU_INTERRUPT_RAISE=0, SRC_ACK=0, BUS_DATA=Z.
  - pending=0, prev_irq=0, enable=4'hF, vector=0, state=IDLE.
  - For round-robin builds, last=3, so the first search starts at source 0.
- Request latency: SRC_IRQ[i] first sampled high at edge k → pending[i]=1 after edge k → CPU_INTERRUPT_RAISE=1 after edge k+1.
- Acknowledge: CPU_INTERRUPT_ACK sampled high at edge a → after edge a, RAISE=0 and SRC_ACK[vector]=1 for exactly one cycle → GAP → IDLE after edge a+2. The earliest next RAISE is after edge a+3.
- A source whose SRC_IRQ stays high after SRC_ACK does not re-pend, because pending only sets on a rising edge. It must drop and re-raise its request.
- Bus read data is registered: BUS_ADDR/BUS_WE sampled at edge r → BUS_DATA driven during the cycle after edge r, then Z again unless the read continues.
- Reset asserted mid-handshake, in any state, returns everything to reset values at that edge. No SRC_ACK pulse is issued.

## Configuration
- IRQ_ROUND_ROBIN_EN:
  - Defined: a register last[1:0] is updated to vector on entry to ACK. Selection searches eligible sources starting at last+1 and wraps 3→0.
  - Undefined: fixed lowest-index priority, and the last register is not built.

## Test plan
- Single request: raise SRC_IRQ=4'b0001, ack 3 cycles after RAISE. RAISE must go high 2 cycles after the IRQ edge. SRC_ACK=4'b0001 must pulse for 1 cycle. A status read must return 8'h00 after GAP.
- Simultaneous requests: SRC_IRQ=4'b0110 in one cycle.
  - Fixed priority: vector read returns 8'h81, then 8'h82 after the first ack.
  - Round-robin from reset: same order. With a further 4'b0010 re-raise, source 2 must be served before source 1.
- Masking: write 8'h0E to BASE+1, then raise SRC_IRQ[0]. No RAISE occurs and status reads 8'h01. Writing 8'h0F must produce RAISE 1 cycle later.
- Set/clear collision: re-raise SRC_IRQ[2] (low→high) on the same edge its ack clears pending[2]. pending[2] must remain 1 and a second RAISE must follow GAP.
- Bus contention: read address 8'hF3 and perform a write to BASE+1. BUS_DATA must stay Z throughout. The mask read-back must equal the written value [3:0].
- Reset during RAISE with vector=1: SRC_ACK stays 0. After reset, status reads 8'h00, mask reads 8'h0F, and RAISE is 0.

Source files
------------

// File: rtl/bus_interrupt_arbiter.sv
// Four-source interrupt arbiter and 8-bit bus peripheral; define IRQ_ROUND_ROBIN_EN for round-robin selection.
// IRQ edge to CPU_INTERRUPT_RAISE in 2 cycles, reads answer 1 cycle after the address; sources hold IRQ until acked.
module bus_interrupt_arbiter #(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         NUM_SRC   = 4
) (
    input  logic       CLK_100,
    input  logic       RESET,
    input  logic [3:0] SRC_IRQ,
    output logic [3:0] SRC_ACK,
    output logic       CPU_INTERRUPT_RAISE,
    input  logic       CPU_INTERRUPT_ACK,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAISE,
        S_ACK,
        S_GAP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] prev_irq;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] ack_onehot;
    logic [1:0]         vector;
    logic [1:0]         vector_nxt;
    logic [1:0]         sel_idx;
    logic               sel_vld;
    logic               busy;
    logic               rd_vld;
    logic               rd_hit;
    logic [7:0]         rd_dat;
    logic [7:0]         rd_dat_nxt;

    assign irq_rise = SRC_IRQ & ~prev_irq;
    assign eligible = pending & enable;
    assign busy     = (state != S_IDLE);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [1:0] last;
    logic [1:0] cand;

    // Search starts just after the last served source and wraps 3 -> 0.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = last + 2'(k);
            if (!sel_vld && eligible[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_ff @(posedge CLK_100) begin
        if (RESET) begin
            last <= 2'd3;
        end else if (state == S_RAISE && state_nxt == S_ACK) begin
            last <= vector;
        end
    end
`else
    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                sel_vld = 1'b1;
                sel_idx = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        vector_nxt = vector;
        pend_clr   = '0;
        case (state)
            S_IDLE: begin
                if (sel_vld) begin
                    vector_nxt = sel_idx;
                    state_nxt  = S_RAISE;
                end
            end
            S_RAISE: begin
                if (CPU_INTERRUPT_ACK) begin
                    pend_clr[vector] = 1'b1;
                    state_nxt        = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_onehot         = '0;
        ack_onehot[vector] = 1'b1;
    end

    always_comb begin
        rd_hit     = 1'b0;
        rd_dat_nxt = 8'h00;
        if (!BUS_WE) begin
            if (BUS_ADDR == BASE_ADDR) begin
                rd_hit     = 1'b1;
                rd_dat_nxt = {busy, 3'b000, pending};
            end else if (BUS_ADDR == BASE_ADDR + 8'd1) begin
                rd_hit     = 1'b1;
                rd_dat_nxt = {4'h0, enable};
            end else if (BUS_ADDR == BASE_ADDR + 8'd2) begin
                rd_hit     = 1'b1;
                rd_dat_nxt = {busy, 5'b00000, vector};
            end
        end
    end

    // Outputs are decoded from the next state so they leave straight from flops.
    always_ff @(posedge CLK_100) begin
        if (RESET) begin
            state               <= S_IDLE;
            vector              <= 2'd0;
            prev_irq            <= '0;
            pending             <= '0;
            enable              <= '1;
            CPU_INTERRUPT_RAISE <= 1'b0;
            SRC_ACK             <= '0;
            rd_vld              <= 1'b0;
            rd_dat              <= 8'h00;
        end else begin
            state               <= state_nxt;
            vector              <= vector_nxt;
            prev_irq            <= SRC_IRQ;
            pending             <= (pending & ~pend_clr) | irq_rise;
            CPU_INTERRUPT_RAISE <= (state_nxt == S_RAISE);
            SRC_ACK             <= (state_nxt == S_ACK) ? ack_onehot : '0;
            rd_vld              <= rd_hit;
            rd_dat              <= rd_dat_nxt;
            if (BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1) begin
                enable <= BUS_DATA[NUM_SRC-1:0];
            end
        end
    end

    assign BUS_DATA = rd_vld ? rd_dat : 8'hzz;

    a_ack_onehot: assert property (@(posedge CLK_100) disable iff (RESET) $onehot0(SRC_ACK));
    a_raise_xor_ack: assert property (@(posedge CLK_100) disable iff (RESET)
        !(CPU_INTERRUPT_RAISE && (SRC_ACK != '0)));

endmodule

// File: tb/tb_bus_interrupt_arbiter.sv
// Directed and randomized bench for bus_interrupt_arbiter against a behavioural model.
module tb_bus_interrupt_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_irq;
    logic [3:0] src_ack;
    logic       raise;
    logic       cpu_ack;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       drv_en;
    logic [7:0] drv_dat;
    tri1  [7:0] bus_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: pending/enable as arrays, the served source and a cool-down count.
    int m_pend[4];
    int m_en[4];
    int m_prev[4];
    int m_cur;
    int m_cool;
    int m_vec;
    int m_ack;
    int m_bus;
`ifdef IRQ_ROUND_ROBIN_EN
    int m_last;
`endif

    assign bus_data = drv_en ? drv_dat : 8'hzz;
    always #5 clk = ~clk;

    bus_interrupt_arbiter dut (
        .CLK_100             (clk),
        .RESET               (rst),
        .SRC_IRQ             (src_irq),
        .SRC_ACK             (src_ack),
        .CPU_INTERRUPT_RAISE (raise),
        .CPU_INTERRUPT_ACK   (cpu_ack),
        .BUS_ADDR            (bus_addr),
        .BUS_DATA            (bus_data),
        .BUS_WE              (bus_we)
    );

    function automatic void model_step(input logic [3:0] irq, input logic ack, input logic we,
                                       input logic [7:0] addr, input logic [7:0] data, input logic rst_i);
        int busy, pend_val, en_val, start, idx, clr;
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0; m_en[i] = 1; m_prev[i] = 0;
            end
            m_cur = -1; m_cool = 0; m_vec = 0; m_ack = 0; m_bus = 255;
`ifdef IRQ_ROUND_ROBIN_EN
            m_last = 3;
`endif
            return;
        end
        busy = (m_cur >= 0 || m_cool > 0) ? 1 : 0;
        pend_val = 0;
        en_val = 0;
        for (int i = 0; i < 4; i++) begin
            pend_val += m_pend[i] * (1 << i);
            en_val   += m_en[i] * (1 << i);
        end
        m_bus = 255;
        if (!we && addr == 8'hF0) m_bus = busy * 128 + pend_val;
        else if (!we && addr == 8'hF1) m_bus = en_val;
        else if (!we && addr == 8'hF2) m_bus = busy * 128 + m_vec;
        m_ack = 0;
        clr = -1;
        if (m_cur < 0) begin
            if (m_cool > 0) m_cool--;
            else begin
`ifdef IRQ_ROUND_ROBIN_EN
                start = (m_last + 1) % 4;
`else
                start = 0;
`endif
                for (int k = 0; k < 4; k++) begin
                    idx = (start + k) % 4;
                    if (m_cur < 0 && m_pend[idx] == 1 && m_en[idx] == 1) begin
                        m_cur = idx; m_vec = idx;
                    end
                end
            end
        end else if (ack) begin
            clr = m_cur; m_ack = 1 << m_cur; m_cur = -1; m_cool = 2;
`ifdef IRQ_ROUND_ROBIN_EN
            m_last = clr;
`endif
        end
        if (clr >= 0) m_pend[clr] = 0;
        for (int i = 0; i < 4; i++) begin
            if (irq[i] && m_prev[i] == 0) m_pend[i] = 1;
            m_prev[i] = irq[i] ? 1 : 0;
        end
        if (we && addr == 8'hF1)
            for (int i = 0; i < 4; i++) m_en[i] = data[i] ? 1 : 0;
    endfunction

    task automatic cycle(input logic [3:0] irq, input logic ack, input logic we,
                         input logic [7:0] addr, input logic [7:0] data, input logic rst_i);
        src_irq = irq; cpu_ack = ack; bus_we = we; bus_addr = addr; rst = rst_i;
        drv_en = we; drv_dat = data;
        model_step(irq, ack, we, addr, data, rst_i);
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        #1;
    endtask

    task automatic idle(input logic [3:0] irq);
        cycle(irq, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [3:0] irq, input logic [7:0] addr);
        cycle(irq, 1'b0, 1'b0, addr, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [3:0] irq, input logic [7:0] addr, input logic [7:0] data);
        cycle(irq, 1'b0, 1'b1, addr, data, 1'b0);
    endtask

    task automatic test_reset();
        cycle(4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        cycle(4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL reset_raise got=%b want=0", raise); end
        n_checks++; if (src_ack !== 4'h0) begin n_fail++; $display("FAIL reset_src_ack got=%h want=0", src_ack); end
        n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL reset_bus_z got=%h want=FF(pulled)", bus_data); end
        rd(4'h0, 8'hF0);
        n_checks++; if (bus_data !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%h want=00", bus_data); end
        rd(4'h0, 8'hF1);
        n_checks++; if (bus_data !== 8'h0F) begin n_fail++; $display("FAIL reset_mask got=%h want=0F", bus_data); end
        rd(4'h0, 8'hF2);
        n_checks++; if (bus_data !== 8'h00) begin n_fail++; $display("FAIL reset_vector got=%h want=00", bus_data); end
        idle(4'h0);
        n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL reset_bus_release got=%h want=FF", bus_data); end
    endtask

    task automatic test_single();
        idle(4'b0001);
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL single_raise_early got=%b want=0", raise); end
        idle(4'b0001);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL single_raise got=%b want=1", raise); end
        idle(4'b0001);
        idle(4'b0001);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL single_raise_hold got=%b want=1", raise); end
        cycle(4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL single_raise_drop got=%b want=0", raise); end
        n_checks++; if (src_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b want=0001", src_ack); end
        idle(4'b0000);
        n_checks++; if (src_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse got=%b want=0000", src_ack); end
        idle(4'b0000);
        rd(4'b0000, 8'hF0);
        n_checks++; if (bus_data !== 8'h00) begin n_fail++; $display("FAIL single_status got=%h want=00", bus_data); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] first_vec, second_vec;
        logic [3:0] first_mask, second_mask;
`ifdef IRQ_ROUND_ROBIN_EN
        first_vec = 8'h82; first_mask = 4'b0100; second_vec = 8'h81; second_mask = 4'b0010;
`else
        first_vec = 8'h81; first_mask = 4'b0010; second_vec = 8'h82; second_mask = 4'b0100;
`endif
        cycle(4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(4'b0110);
        idle(4'b0110);
        rd(4'b0110, 8'hF2);
        n_checks++; if (bus_data !== 8'h81) begin n_fail++; $display("FAIL simul_vec0 got=%h want=81", bus_data); end
        cycle(4'b0110, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (src_ack !== 4'b0010) begin n_fail++; $display("FAIL simul_ack0 got=%b want=0010", src_ack); end
        idle(4'b0100);
        idle(4'b0110);
        idle(4'b0110);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL simul_raise1 got=%b want=1", raise); end
        rd(4'b0110, 8'hF2);
        n_checks++; if (bus_data !== first_vec) begin n_fail++; $display("FAIL simul_vec1 got=%h want=%h", bus_data, first_vec); end
        cycle(4'b0110, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (src_ack !== first_mask) begin n_fail++; $display("FAIL simul_ack1 got=%b want=%b", src_ack, first_mask); end
        idle(second_mask);
        idle(second_mask);
        idle(second_mask);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL simul_raise2 got=%b want=1", raise); end
        rd(second_mask, 8'hF2);
        n_checks++; if (bus_data !== second_vec) begin n_fail++; $display("FAIL simul_vec2 got=%h want=%h", bus_data, second_vec); end
        cycle(second_mask, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (src_ack !== second_mask) begin n_fail++; $display("FAIL simul_ack2 got=%b want=%b", src_ack, second_mask); end
        idle(4'h0);
        idle(4'h0);
    endtask

    task automatic test_mask();
        wr(4'h0, 8'hF1, 8'h0E);
        idle(4'b0001);
        idle(4'b0001);
        idle(4'b0001);
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL mask_blocks got=%b want=0", raise); end
        rd(4'b0001, 8'hF0);
        n_checks++; if (bus_data !== 8'h01) begin n_fail++; $display("FAIL mask_status got=%h want=01", bus_data); end
        idle(4'b0001);
        wr(4'b0001, 8'hF1, 8'h0F);
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_early got=%b want=0", raise); end
        idle(4'b0001);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL mask_unmask_raise got=%b want=1", raise); end
        cycle(4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (src_ack !== 4'b0001) begin n_fail++; $display("FAIL mask_ack got=%b want=0001", src_ack); end
        idle(4'h0);
        idle(4'h0);
    endtask

    task automatic test_collision();
        idle(4'b0100);
        idle(4'b0100);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL coll_raise got=%b want=1", raise); end
        idle(4'b0000);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL coll_raise_held got=%b want=1", raise); end
        cycle(4'b0100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (src_ack !== 4'b0100) begin n_fail++; $display("FAIL coll_ack got=%b want=0100", src_ack); end
        rd(4'b0100, 8'hF0);
        n_checks++; if (bus_data !== 8'h84) begin n_fail++; $display("FAIL coll_status got=%h want=84", bus_data); end
        idle(4'b0100);
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL coll_gap got=%b want=0", raise); end
        idle(4'b0100);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL coll_reraise got=%b want=1", raise); end
        cycle(4'b0100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++; if (src_ack !== 4'b0100) begin n_fail++; $display("FAIL coll_ack2 got=%b want=0100", src_ack); end
        idle(4'h0);
        idle(4'h0);
    endtask

    task automatic test_bus();
        rd(4'h0, 8'hF3);
        n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL bus_unmapped got=%h want=FF", bus_data); end
        idle(4'h0);
        wr(4'h0, 8'hF1, 8'h05);
        n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL bus_wr_mask_z got=%h want=FF", bus_data); end
        wr(4'h0, 8'hF0, 8'hAA);
        n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL bus_wr_status_z got=%h want=FF", bus_data); end
        wr(4'h0, 8'hF2, 8'h55);
        n_checks++; if (bus_data !== 8'hFF) begin n_fail++; $display("FAIL bus_wr_vec_z got=%h want=FF", bus_data); end
        rd(4'h0, 8'hF1);
        n_checks++; if (bus_data !== 8'h05) begin n_fail++; $display("FAIL bus_mask_rb got=%h want=05", bus_data); end
        rd(4'h0, 8'hF0);
        n_checks++; if (bus_data !== 8'h00) begin n_fail++; $display("FAIL bus_status_ro got=%h want=00", bus_data); end
        idle(4'h0);
        wr(4'h0, 8'hF1, 8'hA3);
        rd(4'h0, 8'hF1);
        n_checks++; if (bus_data !== 8'h03) begin n_fail++; $display("FAIL bus_mask_nibble got=%h want=03", bus_data); end
        idle(4'h0);
        wr(4'h0, 8'hF1, 8'h0F);
        idle(4'h0);
    endtask

    task automatic test_reset_mid();
        idle(4'b0010);
        idle(4'b0010);
        n_checks++; if (raise !== 1'b1) begin n_fail++; $display("FAIL rstmid_raise got=%b want=1", raise); end
        rd(4'b0010, 8'hF2);
        n_checks++; if (bus_data !== 8'h81) begin n_fail++; $display("FAIL rstmid_vec got=%h want=81", bus_data); end
        cycle(4'b0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++; if (src_ack !== 4'h0) begin n_fail++; $display("FAIL rstmid_ack got=%b want=0000", src_ack); end
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL rstmid_raise_clr got=%b want=0", raise); end
        idle(4'h0);
        n_checks++; if (src_ack !== 4'h0) begin n_fail++; $display("FAIL rstmid_ack_after got=%b want=0000", src_ack); end
        rd(4'h0, 8'hF0);
        n_checks++; if (bus_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_status got=%h want=00", bus_data); end
        rd(4'h0, 8'hF1);
        n_checks++; if (bus_data !== 8'h0F) begin n_fail++; $display("FAIL rstmid_mask got=%h want=0F", bus_data); end
        n_checks++; if (raise !== 1'b0) begin n_fail++; $display("FAIL rstmid_raise_end got=%b want=0", raise); end
    endtask

    task automatic test_random();
        logic [3:0] irq = 4'h0;
        logic       ack, we, rs;
        logic       prev_rd = 1'b0;
        logic [7:0] addr, data;
        int         r;
        cycle(4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            ack  = (m_cur >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            r    = $urandom_range(0, 9);
            we   = 1'b0;
            addr = 8'h00;
            data = 8'($urandom);
            if (r < 4) addr = 8'hF0 + 8'(r);
            else if (r < 6 && !prev_rd) begin
                we   = 1'b1;
                addr = (r == 4) ? 8'hF1 : 8'hF0 + 8'($urandom_range(0, 3));
            end
            prev_rd = !we && addr >= 8'hF0 && addr <= 8'hF2;
            rs = ($urandom_range(0, 399) == 0);
            cycle(irq, ack, we, addr, data, rs);
            n_checks++; if (raise !== (m_cur >= 0)) begin n_fail++; $display("FAIL rand_raise cyc=%0d got=%b want=%b", c, raise, (m_cur >= 0)); end
            n_checks++; if (src_ack !== 4'(m_ack)) begin n_fail++; $display("FAIL rand_ack cyc=%0d got=%b want=%b", c, src_ack, 4'(m_ack)); end
            n_checks++; if (bus_data !== 8'(m_bus)) begin n_fail++; $display("FAIL rand_bus cyc=%0d got=%h want=%h", c, bus_data, 8'(m_bus)); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv_en = 1'b0; drv_dat = 8'h00; rst = 1'b1; src_irq = 4'h0;
        cpu_ack = 1'b0; bus_addr = 8'h00; bus_we = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_mask();
        test_collision();
        test_bus();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
